// File: rtl/pl_hazard_ctrl.sv
// pl_hazard_ctrl
//   Hazard and forwarding controller for the 5-stage pipeline.
//   - Produces operand-forwarding selects for the ID stage (fwda/fwdb).
//   - Detects load-use hazards and stalls on a busy mult/div unit. A stall
//     freezes PC and IF/ID (wpc/wir low) and injects a bubble into ID/EX.
//   - Tracks an in-flight mult/div op with a down-counter (md_cnt_q).
//   - Counts stall cycles in a saturating counter.
//
// Handshake: md_issue is a single-cycle start strobe. The unit accepts it
//   unconditionally. md_busy stays high for MD_LAT cycles after the issue edge.
//
// Ports
//   clk, clrn              clock, synchronous active-low reset
//   rs, rt                 ID-stage source registers
//   d_use_rs, d_use_rt     ID instruction reads rs / rt
//   d_mdiv, d_usehilo      ID instruction writes / reads HI/LO
//   ewreg, em2reg, ern     ID/EX write flag, load flag, destination
//   mwreg, mm2reg, mrn     EX/MEM write flag, load flag, destination
//   wpc, wir, d_bubble     pipeline stall controls
//   md_issue, md_busy      mult/div start strobe / occupancy
//   fwda, fwdb             00 regfile, 01 EX alu, 10 MEM alu, 11 MEM load
//   stall_cnt              saturating stall-cycle count
module pl_hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             d_use_rs,
  input  logic             d_use_rt,
  input  logic             d_mdiv,
  input  logic             d_usehilo,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       ern,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [4:0]       mrn,
  output logic             wpc,
  output logic             wir,
  output logic             d_bubble,
  output logic             md_issue,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] MD_LAT_C = 4'(MD_LAT);

  logic [3:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             luse, mdst, stall;

  // Forwarding priority: the youngest producer (ID/EX) wins. A load still in
  // ID/EX cannot forward; that case is covered by the load-use stall.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] x,
    input logic       e_wreg,
    input logic       e_m2reg,
    input logic [4:0] e_rn,
    input logic       m_wreg,
    input logic       m_m2reg,
    input logic [4:0] m_rn
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (e_wreg && !e_m2reg && (e_rn == x) && (e_rn != 5'd0))
      sel = 2'b01;
    else if (m_wreg && !m_m2reg && (m_rn == x) && (m_rn != 5'd0))
      sel = 2'b10;
    else if (m_wreg && m_m2reg && (m_rn == x) && (m_rn != 5'd0))
      sel = 2'b11;
    return sel;
  endfunction

  always_comb begin
    fwda = fwd_sel(rs, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
    fwdb = fwd_sel(rt, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
  end

  always_comb begin
    md_busy  = (md_cnt_q != 4'd0);
    luse     = ewreg && em2reg && (ern != 5'd0) &&
               ((d_use_rs && (ern == rs)) || (d_use_rt && (ern == rt)));
    mdst     = md_busy && (d_mdiv || d_usehilo);
    stall    = luse || mdst;
    wpc      = !stall;
    wir      = !stall;
    d_bubble = stall;
    // A stalled mult/div must not start; it re-presents next cycle.
    md_issue = d_mdiv && !stall;
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_issue)
      md_cnt_d = MD_LAT_C;
    else if (md_cnt_q != 4'd0)
      md_cnt_d = md_cnt_q - 4'd1;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Directed bench for pl_hazard_ctrl. Inputs change 1 ns after a rising edge;
// outputs are sampled 2 ns after the edge.
// A second instance with CNT_W=4 is held under a permanent load-use stall.
module tb_pl_hazard_ctrl;

  logic       clk = 1'b0;
  logic       clrn;
  logic [4:0] rs, rt, ern, mrn;
  logic       d_use_rs, d_use_rt, d_mdiv, d_usehilo;
  logic       ewreg, em2reg, mwreg, mm2reg;
  logic       wpc, wir, d_bubble, md_issue, md_busy;
  logic [1:0] fwda, fwdb;
  logic [15:0] stall_cnt;

  logic       s_wpc, s_wir, s_bubble, s_issue, s_busy;
  logic [1:0] s_fwda, s_fwdb;
  logic [3:0] s_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pl_hazard_ctrl #(.MD_LAT(4), .CNT_W(16)) u_dut (
    .clk(clk), .clrn(clrn), .rs(rs), .rt(rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .d_mdiv(d_mdiv), .d_usehilo(d_usehilo),
    .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
    .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn),
    .wpc(wpc), .wir(wir), .d_bubble(d_bubble), .md_issue(md_issue),
    .fwda(fwda), .fwdb(fwdb), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  // Permanent load-use: lw to $1 in ID/EX, ID reads rs=$1.
  pl_hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) u_sat (
    .clk(clk), .clrn(clrn), .rs(5'd1), .rt(5'd0),
    .d_use_rs(1'b1), .d_use_rt(1'b0),
    .d_mdiv(1'b0), .d_usehilo(1'b0),
    .ewreg(1'b1), .em2reg(1'b1), .ern(5'd1),
    .mwreg(1'b0), .mm2reg(1'b0), .mrn(5'd0),
    .wpc(s_wpc), .wir(s_wir), .d_bubble(s_bubble), .md_issue(s_issue),
    .fwda(s_fwda), .fwdb(s_fwdb), .md_busy(s_busy), .stall_cnt(s_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rs = 5'd0; rt = 5'd0; d_use_rs = 1'b0; d_use_rt = 1'b0;
    d_mdiv = 1'b0; d_usehilo = 1'b0;
    ewreg = 1'b0; em2reg = 1'b0; ern = 5'd0;
    mwreg = 1'b0; mm2reg = 1'b0; mrn = 5'd0;
  endtask

  // Stall controls as a packed triple {wpc, wir, d_bubble}.
  function automatic logic [2:0] ctl();
    return {wpc, wir, d_bubble};
  endfunction

  initial begin
    idle();
    clrn = 1'b0;
    // ---------------- reset ----------------
    tick(); tick();
    settle();
    check("rst_ctl", ctl(), 3'b110);
    check("rst_issue", md_issue, 1'b0);
    check("rst_fwd", {fwda, fwdb}, 4'b0000);
    check("rst_busy", md_busy, 1'b0);
    check("rst_cnt", stall_cnt, 16'd0);
    clrn = 1'b1;

    // ---------------- forwarding ----------------
    ern = 5'd5; ewreg = 1'b1; em2reg = 1'b0;
    mrn = 5'd5; mwreg = 1'b1; mm2reg = 1'b0;
    rs = 5'd5; rt = 5'd5;
    settle();
    check("fwd_ex_over_mem_a", fwda, 2'b01);
    check("fwd_ex_over_mem_b", fwdb, 2'b01);
    ewreg = 1'b0; settle();
    check("fwd_mem_alu", fwda, 2'b10);
    mm2reg = 1'b1; settle();
    check("fwd_mem_load", fwda, 2'b11);
    check("fwd_no_stall_mem_load", ctl(), 3'b110);
    rt = 5'd6; settle();
    check("fwd_rt_nomatch", fwdb, 2'b00);
    ewreg = 1'b1; ern = 5'd0; mrn = 5'd0; rs = 5'd0; settle();
    check("fwd_reg0", fwda, 2'b00);
    tick();
    check("fwd_cnt_unchanged", stall_cnt, 16'd0);

    // ---------------- load-use ----------------
    idle();
    ewreg = 1'b1; em2reg = 1'b1; ern = 5'd8; rt = 5'd8; d_use_rt = 1'b1;
    settle();
    check("luse_ctl", ctl(), 3'b001);
    check("luse_issue", md_issue, 1'b0);
    tick();
    // Bubble now in ID/EX, load in EX/MEM.
    ewreg = 1'b0; em2reg = 1'b0; ern = 5'd0;
    mwreg = 1'b1; mm2reg = 1'b1; mrn = 5'd8;
    settle();
    check("luse_release", ctl(), 3'b110);
    check("luse_fwd_load", fwdb, 2'b11);
    check("luse_cnt", stall_cnt, 16'd1);
    idle();
    ewreg = 1'b1; em2reg = 1'b1; ern = 5'd8; rt = 5'd8; d_use_rt = 1'b0;
    settle();
    check("luse_no_use", ctl(), 3'b110);
    ern = 5'd0; rt = 5'd0; d_use_rt = 1'b1; settle();
    check("luse_reg0", ctl(), 3'b110);
    tick();
    check("luse_cnt_hold", stall_cnt, 16'd1);

    // ---------------- mult/div latency ----------------
    idle();
    d_mdiv = 1'b1; settle();
    check("md_issue", md_issue, 1'b1);
    check("md_issue_ctl", ctl(), 3'b110);
    tick();
    d_mdiv = 1'b0; d_usehilo = 1'b1; settle();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("md_busy_%0d", i), md_busy, 1'b1);
      check($sformatf("md_stall_%0d", i), ctl(), 3'b001);
      tick();
    end
    check("md_done_busy", md_busy, 1'b0);
    check("md_done_ctl", ctl(), 3'b110);
    check("md_cnt_stalls", stall_cnt, 16'd5);

    // Back-to-back mult: second stalls until counter drains.
    d_usehilo = 1'b0; d_mdiv = 1'b1; settle();
    check("b2b_first_issue", md_issue, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b_wait_%0d", i), {md_issue, d_bubble}, 2'b01);
      tick();
    end
    check("b2b_second_issue", {md_issue, md_busy}, 2'b10);
    tick();
    check("b2b_reload", md_busy, 1'b1);
    check("b2b_cnt", stall_cnt, 16'd9);

    // luse and mdst together: one stall, counter not reloaded.
    ewreg = 1'b1; em2reg = 1'b1; ern = 5'd3; rs = 5'd3; d_use_rs = 1'b1;
    settle();
    check("both_ctl", ctl(), 3'b001);
    check("both_issue", md_issue, 1'b0);
    tick();
    check("both_cnt", stall_cnt, 16'd10);
    idle();
    tick(); tick(); tick();
    check("both_no_reload", md_busy, 1'b0);

    // d_mdiv blocked by luse while unit idle: no load.
    d_mdiv = 1'b1; ewreg = 1'b1; em2reg = 1'b1; ern = 5'd3; rs = 5'd3; d_use_rs = 1'b1;
    settle();
    check("luse_md_issue", md_issue, 1'b0);
    tick();
    check("luse_md_busy", md_busy, 1'b0);
    check("luse_md_cnt", stall_cnt, 16'd11);

    // ---------------- reset mid-operation ----------------
    idle();
    d_mdiv = 1'b1; tick();
    d_mdiv = 1'b0; d_usehilo = 1'b1;
    tick(); tick();
    check("mid_pre_cnt", stall_cnt, 16'd13);
    clrn = 1'b0;
    tick();
    clrn = 1'b1; settle();
    check("mid_rst_busy", md_busy, 1'b0);
    check("mid_rst_cnt", stall_cnt, 16'd0);
    check("mid_rst_release", ctl(), 3'b110);
    // Reset wins over a simultaneous issue.
    d_usehilo = 1'b0; d_mdiv = 1'b1; clrn = 1'b0;
    tick();
    clrn = 1'b1; d_mdiv = 1'b0; settle();
    check("rst_over_issue", md_busy, 1'b0);

    // ---------------- saturation (CNT_W=4) ----------------
    check("sat_after_rst", s_cnt, 4'd0);
    for (int i = 0; i < 14; i++) tick();
    check("sat_14", s_cnt, 4'd14);
    tick();
    check("sat_15", s_cnt, 4'd15);
    for (int i = 0; i < 5; i++) tick();
    check("sat_hold", s_cnt, 4'd15);
    check("sat_ctl", {s_wpc, s_wir, s_bubble}, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
